o_tile_accum_upd: RTL

Parametrised output-accumulator update stage for the tiled (flash-style) attention pipeline. Per query row-block it performs O_new = diag(coef)·O_old + P·V, streaming the row-block across N_CT column tiles. Each tile is read from O BRAM through bram_manager, merged with the P·V tile delivered by the upstream SA stage over a valid/ready handshake, and written back. Supports a first-KV-block mode (O_new = P·V, no read) and configurable tile geometry and fixed-point format.

---
 rtl/o_tile_accum_upd.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/o_tile_accum_upd.sv
// o_tile_accum_upd: output-accumulator update stage for tiled attention.
// For one query row-block it streams N_CT column tiles, computing
//   O_new = diag(coef) * O_old + P*V
// reading O_old from BRAM, merging with the P*V tile from the SA stage and
// writing the result back. First-KV-block mode skips the read (O_new = P*V).
// Optional feature macro: O_UPD_SAT_EN (saturate the merged sum instead of
// wrapping it to D_W bits).
module o_tile_accum_upd #(
  parameter int D_W    = 16,
  parameter int FRAC   = 8,
  parameter int TIL_R  = 16,
  parameter int TIL_C  = 16,
  parameter int N_CT   = 8,
  parameter int LINE_W = 6,
  parameter int COL_W  = (N_CT > 1) ? $clog2(N_CT) : 1
) (
  input  logic                                  I_CLK,
  input  logic                                  I_RST_N,
  input  logic                                  I_START,
  input  logic                                  I_FIRST,
  input  logic [LINE_W-1:0]                     I_SEL_Q_O,
  input  logic [0:TIL_R-1][D_W-1:0]             I_COEF,
  output logic                                  O_BUSY,
  output logic                                  O_DONE,
  input  logic                                  I_PV_VLD,
  output logic                                  O_PV_RDY,
  input  logic [0:TIL_R-1][0:TIL_C-1][D_W-1:0]  I_PV_MAT,
  output logic                                  O_BRAM_O_ENA,
  output logic                                  O_BRAM_O_WEA,
  output logic [LINE_W-1:0]                     O_BRAM_SEL_O_LINE,
  output logic [COL_W-1:0]                      O_BRAM_SEL_O_COL,
  input  logic                                  I_BRAM_RD_O_VLD,
  input  logic [0:TIL_R-1][0:TIL_C-1][D_W-1:0]  I_BRAM_RD_O_MAT,
  output logic [0:TIL_R-1][0:TIL_C-1][D_W-1:0]  O_BRAM_WR_MAT,
  output logic [1:0]                            O_DBG_STATE
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD_O    = 2'd1,
    S_WAIT_PV = 2'd2,
    S_WR_O    = 2'd3
  } state_t;

  typedef logic [0:TIL_R-1][0:TIL_C-1][D_W-1:0] tile_t;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(N_CT - 1);

  state_t                    state_q, state_d;
  logic [COL_W-1:0]          col_q, col_d;
  logic                      first_q, first_d;
  logic [LINE_W-1:0]         line_q, line_d;
  logic [0:TIL_R-1][D_W-1:0] coef_q, coef_d;
  tile_t                     obuf_q, obuf_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      ena_q, ena_d;
  logic                      wea_q, wea_d;
  logic [LINE_W-1:0]         sel_line_q, sel_line_d;
  logic [COL_W-1:0]          sel_col_q, sel_col_d;
  tile_t                     wr_mat_q, wr_mat_d;
  tile_t                     res_mat;

  // One element of the merge: floor(o*k / 2^FRAC) + pv, narrowed to D_W.
  function automatic logic [D_W-1:0] upd_elem(
    input logic signed [D_W-1:0] o,
    input logic signed [D_W-1:0] k,
    input logic signed [D_W-1:0] pv
  );
    logic signed [2*D_W-1:0] prod;
    logic signed [D_W:0]     scaled;
    logic signed [D_W:0]     sum;
    prod   = (2*D_W)'(o) * (2*D_W)'(k);
    scaled = (D_W+1)'(prod >>> FRAC);
    sum    = scaled + $signed({pv[D_W-1], pv});
`ifdef O_UPD_SAT_EN
    if (sum[D_W] != sum[D_W-1]) begin
      return sum[D_W] ? {1'b1, {(D_W-1){1'b0}}} : {1'b0, {(D_W-1){1'b1}}};
    end
    return sum[D_W-1:0];
`else
    return D_W'(sum);
`endif
  endfunction

  // Merged tile for the current column; first mode passes P*V through.
  always_comb begin
    res_mat = '0;
    for (int r = 0; r < TIL_R; r++) begin
      for (int c = 0; c < TIL_C; c++) begin
        res_mat[r][c] = first_q ? I_PV_MAT[r][c]
                                : upd_elem(obuf_q[r][c], coef_q[r], I_PV_MAT[r][c]);
      end
    end
  end

  // Handshake: a P*V tile transfers on a rising clock edge where
  // I_PV_VLD and O_PV_RDY are both high; O_PV_RDY is high exactly in
  // S_WAIT_PV and never depends on I_PV_VLD. The producer holds the tile
  // stable while I_PV_VLD is high and not yet accepted.
  assign O_PV_RDY = (state_q == S_WAIT_PV);

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    first_d    = first_q;
    line_d     = line_q;
    coef_d     = coef_q;
    obuf_d     = obuf_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ena_d      = ena_q;
    wea_d      = wea_q;
    sel_line_d = sel_line_q;
    sel_col_d  = sel_col_q;
    wr_mat_d   = wr_mat_q;
    case (state_q)
      S_IDLE: begin
        if (I_START) begin
          first_d = I_FIRST;
          line_d  = I_SEL_Q_O;
          coef_d  = I_COEF;
          col_d   = '0;
          busy_d  = 1'b1;
          state_d = I_FIRST ? S_WAIT_PV : S_RD_O;
        end
      end
      S_RD_O: begin
        sel_line_d = line_q;
        sel_col_d  = col_q;
        wea_d      = 1'b0;
        if (I_BRAM_RD_O_VLD) begin
          obuf_d  = I_BRAM_RD_O_MAT;
          ena_d   = 1'b0;
          state_d = S_WAIT_PV;
        end else begin
          ena_d = 1'b1;
        end
      end
      S_WAIT_PV: begin
        if (I_PV_VLD) begin
          wr_mat_d   = res_mat;
          ena_d      = 1'b1;
          wea_d      = 1'b1;
          sel_line_d = line_q;
          sel_col_d  = col_q;
          state_d    = S_WR_O;
        end
      end
      S_WR_O: begin
        ena_d = 1'b0;
        wea_d = 1'b0;
        if (col_q == COL_LAST) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          col_d   = col_q + COL_W'(1);
          state_d = first_q ? S_WAIT_PV : S_RD_O;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset clears everything, including any
  // write strobe currently on the port.
  always_ff @(posedge I_CLK) begin
    if (!I_RST_N) begin
      state_q    <= S_IDLE;
      col_q      <= '0;
      first_q    <= 1'b0;
      line_q     <= '0;
      coef_q     <= '0;
      obuf_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ena_q      <= 1'b0;
      wea_q      <= 1'b0;
      sel_line_q <= '0;
      sel_col_q  <= '0;
      wr_mat_q   <= '0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      first_q    <= first_d;
      line_q     <= line_d;
      coef_q     <= coef_d;
      obuf_q     <= obuf_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ena_q      <= ena_d;
      wea_q      <= wea_d;
      sel_line_q <= sel_line_d;
      sel_col_q  <= sel_col_d;
      wr_mat_q   <= wr_mat_d;
    end
  end

  assign O_BUSY            = busy_q;
  assign O_DONE            = done_q;
  assign O_BRAM_O_ENA      = ena_q;
  assign O_BRAM_O_WEA      = wea_q;
  assign O_BRAM_SEL_O_LINE = sel_line_q;
  assign O_BRAM_SEL_O_COL  = sel_col_q;
  assign O_BRAM_WR_MAT     = wr_mat_q;
  assign O_DBG_STATE       = state_q;

endmodule
